// File: rtl/decode_queue_stage_if.sv
// Handshake/bus bundle between fetch, register file, forwarding network, the
// external decoder and execute around decode_queue_stage. clk/reset are not
// carried here. slave = the decode stage, master = its environment.
interface decode_queue_stage_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int NFWD  = 3,
    parameter int CTL_W = 32
);
    // fetch side
    logic                      in_valid;
    logic                      in_ready;
    logic [XLEN-1:0]           in_pc;
    logic [31:0]               in_instr;
    // pipeline control
    logic                      stall;
    logic                      flush;
    logic                      stall_d;
    logic [$clog2(DEPTH):0]    q_count;
    // register file
    logic [4:0]                ra1;
    logic [4:0]                ra2;
    logic [XLEN-1:0]           rd1;
    logic [XLEN-1:0]           rd2;
    // forwarding channels, channel 0 youngest
    logic [NFWD-1:0]           fwd_valid;
    logic [NFWD*5-1:0]         fwd_dst;
    logic [NFWD*XLEN-1:0]      fwd_data;
    logic [NFWD-1:0]           fwd_pending;
    // external decoder
    logic [31:0]               dec_instr;
    logic [CTL_W-1:0]          dec_ctl;
    logic                      dec_use1;
    logic                      dec_use2;
    // registered bundle to execute
    logic                      out_valid;
    logic [XLEN-1:0]           out_pc;
    logic [31:0]               out_instr;
    logic [CTL_W-1:0]          out_ctl;
    logic [4:0]                out_dst;
    logic [XLEN-1:0]           out_src1;
    logic [XLEN-1:0]           out_src2;

    modport slave (
        input  in_valid, in_pc, in_instr, stall, flush, rd1, rd2,
               fwd_valid, fwd_dst, fwd_data, fwd_pending,
               dec_ctl, dec_use1, dec_use2,
        output in_ready, stall_d, q_count, ra1, ra2, dec_instr,
               out_valid, out_pc, out_instr, out_ctl, out_dst, out_src1, out_src2
    );

    modport master (
        output in_valid, in_pc, in_instr, stall, flush, rd1, rd2,
               fwd_valid, fwd_dst, fwd_data, fwd_pending,
               dec_ctl, dec_use1, dec_use2,
        input  in_ready, stall_d, q_count, ra1, ra2, dec_instr,
               out_valid, out_pc, out_instr, out_ctl, out_dst, out_src1, out_src2
    );
endinterface

// File: rtl/decode_queue_stage.sv
// Purpose: decode stage - DEPTH-entry instruction queue, operand resolution
//          through NFWD forwarding channels with load-use detection, and a
//          registered decoded bundle for execute.
// Latency: entry pushed at edge t into an empty queue is on out_* after t+1;
//          one bundle per cycle sustained.
// Backpressure: in_ready drops at count==DEPTH (no pop-to-push bypass);
//          stall holds the output register and blocks pops; stall_d bubbles.
// Ports: clk, reset (synchronous, active-high) plus the decode_queue_stage_if
//          slave modport (fetch, regfile, forwarding, decoder, execute sides).
// Config: define DECODE_FWD_EN for the forwarding mux; without it, operands
//          come from rd1/rd2 and any matching valid channel stalls.
module decode_queue_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int NFWD  = 3,
    parameter int CTL_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    decode_queue_stage_if.slave   io
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [CTL_W-1:0] out_ctl_q, out_ctl_d;
    logic [4:0]      out_dst_q, out_dst_d;
    logic [XLEN-1:0] out_src1_q, out_src1_d;
    logic [XLEN-1:0] out_src2_q, out_src2_d;

    entry_t          head;
    logic            head_vld;
    logic            in_rdy;
    logic            push;
    logic            pop;
    logic            clr;
    logic [4:0]      ra1, ra2;
    logic [XLEN-1:0] src1_val, src2_val;
    logic            hit1, hit2;
    logic            haz1, haz2;
    logic            stall_d;

    assign head     = mem_q[rd_ptr_q];
    assign head_vld = (count_q != '0);
    assign in_rdy   = (count_q != CW'(DEPTH));
    // flush discards a same-cycle push
    assign push     = io.in_valid & in_rdy & ~io.flush;
    assign ra1      = head.instr[19:15];
    assign ra2      = head.instr[24:20];

`ifdef DECODE_FWD_EN
    logic pend1, pend2;
`endif

    // Operand resolution. Walk from the oldest channel to the youngest so the
    // lowest matching index is the last writer and wins. x0 never matches.
    always_comb begin
        src1_val = (ra1 == 5'd0) ? '0 : io.rd1;
        src2_val = (ra2 == 5'd0) ? '0 : io.rd2;
        hit1     = 1'b0;
        hit2     = 1'b0;
`ifdef DECODE_FWD_EN
        pend1    = 1'b0;
        pend2    = 1'b0;
`endif
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (io.fwd_valid[i] && (io.fwd_dst[i*5 +: 5] == ra1) && (ra1 != 5'd0)) begin
                hit1 = 1'b1;
`ifdef DECODE_FWD_EN
                pend1    = io.fwd_pending[i];
                src1_val = io.fwd_data[i*XLEN +: XLEN];
`endif
            end
            if (io.fwd_valid[i] && (io.fwd_dst[i*5 +: 5] == ra2) && (ra2 != 5'd0)) begin
                hit2 = 1'b1;
`ifdef DECODE_FWD_EN
                pend2    = io.fwd_pending[i];
                src2_val = io.fwd_data[i*XLEN +: XLEN];
`endif
            end
        end
    end

`ifdef DECODE_FWD_EN
    assign haz1 = io.dec_use1 & hit1 & pend1;
    assign haz2 = io.dec_use2 & hit2 & pend2;
`else
    // without a forwarding mux any in-flight writer of a used source blocks
    assign haz1 = io.dec_use1 & hit1;
    assign haz2 = io.dec_use2 & hit2;
`endif

    assign stall_d = head_vld & (haz1 | haz2) & ~io.flush;

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_ctl_d   = out_ctl_q;
        out_dst_d   = out_dst_q;
        out_src1_d  = out_src1_q;
        out_src2_d  = out_src2_q;
        pop         = 1'b0;
        clr         = 1'b0;

        if (io.stall) begin
            // outputs frozen, but a redirect must still empty the queue
            clr = io.flush;
        end else if (io.flush) begin
            out_valid_d = 1'b0;
            clr         = 1'b1;
        end else if (head_vld && !stall_d) begin
            out_valid_d = 1'b1;
            out_pc_d    = head.pc;
            out_instr_d = head.instr;
            out_ctl_d   = io.dec_ctl;
            out_dst_d   = head.instr[11:7];
            out_src1_d  = src1_val;
            out_src2_d  = src2_val;
            pop         = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // power-of-two depth: pointers wrap by natural overflow
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // payload and storage carry no reset; out_valid qualifies them
    always_ff @(posedge clk) begin
        out_pc_q    <= out_pc_d;
        out_instr_q <= out_instr_d;
        out_ctl_q   <= out_ctl_d;
        out_dst_q   <= out_dst_d;
        out_src1_q  <= out_src1_d;
        out_src2_q  <= out_src2_d;
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: io.in_pc, instr: io.in_instr};
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.stall_d   = stall_d;
    assign io.q_count   = count_q;
    assign io.ra1       = ra1;
    assign io.ra2       = ra2;
    assign io.dec_instr = head.instr;
    assign io.out_valid = out_valid_q;
    assign io.out_pc    = out_pc_q;
    assign io.out_instr = out_instr_q;
    assign io.out_ctl   = out_ctl_q;
    assign io.out_dst   = out_dst_q;
    assign io.out_src1  = out_src1_q;
    assign io.out_src2  = out_src2_q;
endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench for decode_queue_stage: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_decode_queue_stage;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int NFWD  = 3;
    localparam int CTL_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    decode_queue_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NFWD(NFWD), .CTL_W(CTL_W)) io ();

    decode_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .NFWD(NFWD), .CTL_W(CTL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    // external decoder stand-in
    function automatic logic [31:0] dec_ctl_f(input logic [31:0] ins);
        return {ins[7:0], ins[31:8]} ^ 32'hC0DE_0000;
    endfunction
    function automatic logic dec_u1(input logic [31:0] ins);
        return ins[0];
    endfunction
    function automatic logic dec_u2(input logic [31:0] ins);
        return ins[1];
    endfunction
    assign io.dec_ctl  = dec_ctl_f(io.dec_instr);
    assign io.dec_use1 = dec_u1(io.dec_instr);
    assign io.dec_use2 = dec_u2(io.dec_instr);

    function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic u1, input logic u2);
        return {7'h11, rs2, rs1, 3'b010, rd, 5'b10101, u2, u1};
    endfunction

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t mq[$];
    logic        e_ov = 1'b0;
    logic [63:0] e_pc, e_s1, e_s2;
    logic [31:0] e_instr, e_ctl;
    logic [4:0]  e_dst;

    function automatic void resolve(input logic [4:0] ra, input logic [63:0] rd,
                                    output logic [63:0] val, output logic haz);
        int hit;
        hit = -1;
        val = rd;
        haz = 1'b0;
        if (ra == 5'd0) begin
            val = '0;
            return;
        end
        for (int i = 0; i < NFWD; i++) begin
            if (io.fwd_valid[i] && io.fwd_dst[i*5 +: 5] == ra) begin
                hit = i;
                break;
            end
        end
        if (hit >= 0) begin
`ifdef DECODE_FWD_EN
            val = io.fwd_data[hit*XLEN +: XLEN];
            haz = io.fwd_pending[hit];
`else
            haz = 1'b1;
`endif
        end
    endfunction

    ent_t        m_h, m_ne;
    logic        m_hv, m_hz1, m_hz2, m_sd, m_push;
    logic [63:0] m_s1, m_s2;

    // compare + model step, mid low phase with inputs stable
    always begin
        @(negedge clk);
        #5;
        if (chk_en) begin
            m_hv = (mq.size() != 0);
            m_s1 = '0; m_s2 = '0; m_hz1 = 1'b0; m_hz2 = 1'b0;
            if (m_hv) begin
                m_h = mq[0];
                resolve(m_h.instr[19:15], io.rd1, m_s1, m_hz1);
                resolve(m_h.instr[24:20], io.rd2, m_s2, m_hz2);
            end
            m_sd = m_hv && ((dec_u1(m_h.instr) && m_hz1) || (dec_u2(m_h.instr) && m_hz2)) && !io.flush;

            chk("in_ready", io.in_ready, mq.size() != DEPTH);
            chk("q_count", io.q_count, mq.size());
            chk("stall_d", io.stall_d, m_sd);
            if (m_hv) begin
                chk("ra1", io.ra1, m_h.instr[19:15]);
                chk("ra2", io.ra2, m_h.instr[24:20]);
                chk("dec_instr", io.dec_instr, m_h.instr);
            end
            chk("out_valid", io.out_valid, e_ov);
            if (e_ov) begin
                chk("out_pc", io.out_pc, e_pc);
                chk("out_instr", io.out_instr, e_instr);
                chk("out_ctl", io.out_ctl, e_ctl);
                chk("out_dst", io.out_dst, e_dst);
                chk("out_src1", io.out_src1, e_s1);
                chk("out_src2", io.out_src2, e_s2);
            end

            m_push     = io.in_valid && (mq.size() != DEPTH) && !io.flush;
            m_ne.pc    = io.in_pc;
            m_ne.instr = io.in_instr;
            if (reset) begin
                mq.delete();
                e_ov = 1'b0;
            end else if (io.stall) begin
                if (io.flush) mq.delete();
                else if (m_push) mq.push_back(m_ne);
            end else if (io.flush) begin
                mq.delete();
                e_ov = 1'b0;
            end else begin
                if (m_hv && !m_sd) begin
                    e_ov    = 1'b1;
                    e_pc    = m_h.pc;
                    e_instr = m_h.instr;
                    e_ctl   = dec_ctl_f(m_h.instr);
                    e_dst   = m_h.instr[11:7];
                    e_s1    = m_s1;
                    e_s2    = m_s2;
                    void'(mq.pop_front());
                end else begin
                    e_ov = 1'b0;
                end
                if (m_push) mq.push_back(m_ne);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        io.in_valid    = 1'b0;
        io.stall       = 1'b0;
        io.flush       = 1'b0;
        io.fwd_valid   = '0;
        io.fwd_pending = '0;
        repeat (6) step();
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish, expected end by %0t", $time);
        $fatal(1, "watchdog");
    end

    int   idx, got;
    logic acc;
    logic [31:0] ins;

    initial begin
        reset          = 1'b1;
        io.in_valid    = 1'b0;
        io.in_pc       = '0;
        io.in_instr    = '0;
        io.stall       = 1'b0;
        io.flush       = 1'b0;
        io.rd1         = 64'h1111;
        io.rd2         = 64'h2222;
        io.fwd_valid   = '0;
        io.fwd_dst     = '0;
        io.fwd_data    = '0;
        io.fwd_pending = '0;
        repeat (3) @(posedge clk);
        step();
        chk_en = 1'b1;
        chk("rst_out_valid", io.out_valid, 1'b0);
        chk("rst_q_count", io.q_count, 0);
        chk("rst_in_ready", io.in_ready, 1'b1);
        chk("rst_stall_d", io.stall_d, 1'b0);
        reset = 1'b0;
        step();

        // stream: six entries, no hazards
        io.in_valid = 1'b1;
        io.in_instr = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        io.in_pc    = 64'h0;
        step();
        chk("stream_cnt0", io.q_count, 1);
        chk("stream_vld0", io.out_valid, 1'b0);
        for (int k = 1; k < 6; k++) begin
            io.in_pc = 64'(4 * k);
            step();
            chk("stream_vld", io.out_valid, 1'b1);
            chk("stream_pc", io.out_pc, 64'(4 * (k - 1)));
            chk("stream_cnt", io.q_count, 1);
        end
        io.in_valid = 1'b0;
        step();
        chk("stream_last_pc", io.out_pc, 64'h14);
        chk("stream_empty", io.q_count, 0);
        step();
        chk("stream_done", io.out_valid, 1'b0);
        quiet();

        // fill under stall, fifth entry waits, order kept across wrap
        io.stall = 1'b1;
        idx = 0;
        got = 0;
        for (int c = 0; c < 14; c++) begin
            io.in_valid = (idx < 5);
            io.in_pc    = 64'h100 + 64'(4 * idx);
            io.in_instr = mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
            if (c == 5) io.stall = 1'b0;
            acc = io.in_valid && io.in_ready;
            step();
            if (acc) idx++;
            if (c == 3) begin
                chk("fill_full_cnt", io.q_count, 4);
                chk("fill_full_rdy", io.in_ready, 1'b0);
            end
            if (c == 4) chk("fill_reject", io.q_count, 4);
            if (io.out_valid) begin
                chk("fill_order", io.out_pc, 64'h100 + 64'(4 * got));
                got++;
            end
        end
        chk("fill_count", got, 5);
        quiet();

        // forward priority
        io.rd1      = 64'h1111;
        io.rd2      = 64'h2222;
        io.in_valid = 1'b1;
        io.in_pc    = 64'h200;
        io.in_instr = mk(5'd5, 5'd0, 5'd9, 1'b1, 1'b0);
        step();
        io.in_valid    = 1'b0;
        io.fwd_valid   = 3'b110;
        io.fwd_dst     = {5'd5, 5'd5, 5'd3};
        io.fwd_data    = {64'hBB, 64'hAA, 64'h0};
        io.fwd_pending = 3'b000;
        #1;
`ifdef DECODE_FWD_EN
        chk("fwd_no_stall", io.stall_d, 1'b0);
        step();
        chk("fwd_vld", io.out_valid, 1'b1);
        chk("fwd_src1", io.out_src1, 64'hAA);
`else
        chk("nofwd_stall", io.stall_d, 1'b1);
        step();
        chk("nofwd_bubble", io.out_valid, 1'b0);
        chk("nofwd_stall2", io.stall_d, 1'b1);
        io.fwd_valid = 3'b000;
        step();
        chk("nofwd_vld", io.out_valid, 1'b1);
        chk("nofwd_src1", io.out_src1, 64'h1111);
`endif
        io.fwd_valid = 3'b000;
        step();

        // x0 never forwards
        io.in_valid = 1'b1;
        io.in_pc    = 64'h204;
        io.in_instr = mk(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        step();
        io.in_valid    = 1'b0;
        io.fwd_valid   = 3'b001;
        io.fwd_dst     = {5'd0, 5'd0, 5'd0};
        io.fwd_data    = {64'h0, 64'h0, 64'hCC};
        io.fwd_pending = 3'b001;
        #1;
        chk("x0_no_stall", io.stall_d, 1'b0);
        step();
        chk("x0_vld", io.out_valid, 1'b1);
        chk("x0_src1", io.out_src1, 64'h0);
        quiet();

        // load-use on rs2 = x7
        io.in_valid = 1'b1;
        io.in_pc    = 64'h208;
        io.in_instr = mk(5'd1, 5'd7, 5'd9, 1'b0, 1'b1);
        step();
        io.in_valid    = 1'b0;
        io.fwd_valid   = 3'b001;
        io.fwd_dst     = {5'd0, 5'd0, 5'd7};
        io.fwd_data    = {64'h0, 64'h0, 64'h77};
        io.fwd_pending = 3'b001;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("lu_stall_d", io.stall_d, 1'b1);
            step();
            chk("lu_bubble", io.out_valid, 1'b0);
        end
        io.fwd_pending = 3'b000;
`ifndef DECODE_FWD_EN
        io.fwd_valid = 3'b000;
`endif
        #1;
        chk("lu_release", io.stall_d, 1'b0);
        step();
        chk("lu_vld", io.out_valid, 1'b1);
`ifdef DECODE_FWD_EN
        chk("lu_src2", io.out_src2, 64'h77);
`else
        chk("lu_src2", io.out_src2, 64'h2222);
`endif
        quiet();

        // flush together with stall, then flush alone
        io.in_instr = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        io.in_valid = 1'b1;
        io.in_pc = 64'h300; step();
        io.in_pc = 64'h304; step();
        io.stall = 1'b1;
        io.in_pc = 64'h308; step();
        io.in_pc = 64'h30C; step();
        io.in_valid = 1'b0;
        chk("fs_cnt3", io.q_count, 3);
        chk("fs_vld", io.out_valid, 1'b1);
        io.flush = 1'b1;
        step();
        chk("fs_hold_vld", io.out_valid, 1'b1);
        chk("fs_hold_pc", io.out_pc, 64'h300);
        chk("fs_cleared", io.q_count, 0);
        io.stall = 1'b0;
        step();
        chk("fs_flush_vld", io.out_valid, 1'b0);
        quiet();

        // randomized traffic, model checks every cycle
        for (int c = 0; c < 2500; c++) begin
            ins        = $urandom;
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            io.in_valid = ($urandom_range(0, 3) != 0);
            io.in_pc    = {$urandom, $urandom};
            io.in_instr = ins;
            io.stall    = ($urandom_range(0, 4) == 0);
            io.flush    = ($urandom_range(0, 19) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            io.rd1      = {$urandom, $urandom};
            io.rd2      = {$urandom, $urandom};
            for (int i = 0; i < NFWD; i++) begin
                io.fwd_valid[i]            = $urandom_range(0, 1) == 1;
                io.fwd_dst[i*5 +: 5]       = 5'($urandom_range(0, 7));
                io.fwd_data[i*XLEN +: XLEN] = {$urandom, $urandom};
                io.fwd_pending[i]          = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        reset = 1'b0;
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
